// File: rtl/mem_arb_pkg.sv
// Shared RAM command codes plus the arbiter's state and requester-id types.
// The command codes are also used by the CPU and the StateController.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;
  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  function automatic logic cmd_legal(logic [1:0] c);
    return (c == MREAD) || (c == MWRITE);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; the caller owns last_gnt.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;
  // On a tie the requester not served last wins.
  assign winner = (req0 & req1) ? ~last_gnt : (req1 ? REQ1 : REQ0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU (0) and the loader/debug port (1).
// One access at a time, round-robin on ties, fully registered outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err,
  output logic          busy,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int NREQ = 2;

  logic [NREQ-1:0][1:0]    cmd_in;
  logic [NREQ-1:0][AW-1:0] addr_in;
  logic [NREQ-1:0][DW-1:0] wdata_in;
  logic [NREQ-1:0]         gnt_q, rvalid_q;
  logic [NREQ-1:0][DW-1:0] rdata_q;

  arb_state_e state;
  req_id_t    last_gnt, win_id, pick_id;
  logic       pick_vld;
  logic [1:0] acc_cmd;

  assign cmd_in   = {cmd1, cmd0};
  assign addr_in  = {addr1, addr0};
  assign wdata_in = {wdata1, wdata0};

  assign {gnt1, gnt0}       = gnt_q;
  assign {rvalid1, rvalid0} = rvalid_q;
  assign rdata0             = rdata_q[0];
  assign rdata1             = rdata_q[1];

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (pick_vld),
    .winner   (pick_id)
  );

  // The ACCESS-cycle outputs are loaded on the IDLE->ACCESS edge so that the
  // grant and RAM command appear one cycle after the request, straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last_gnt  <= REQ1;
      win_id    <= REQ0;
      acc_cmd   <= MNONE;
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_cmd  <= MNONE;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state          <= ST_ACCESS;
            busy           <= 1'b1;
            win_id         <= pick_id;
            last_gnt       <= pick_id;
            gnt_q[pick_id] <= 1'b1;
            acc_cmd        <= cmd_in[pick_id];
            mem_addr       <= addr_in[pick_id];
            mem_wdata      <= wdata_in[pick_id];
            if (cmd_legal(cmd_in[pick_id])) mem_cmd <= cmd_in[pick_id];
            else                            err     <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (acc_cmd == MREAD) begin
            state <= ST_RDATA;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RDATA: begin
          state            <= ST_IDLE;
          busy             <= 1'b0;
          rvalid_q[win_id] <= 1'b1;
          for (int i = 0; i < NREQ; i++)
            if (win_id == req_id_t'(i)) rdata_q[i] <= mem_rdata;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, two corner sequences,
// then randomized traffic against a transaction-timeline reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NR = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [1:0]    cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          err, busy;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          ram_load;
  logic [DW-1:0] ram_seed;
  logic [DW-1:0] ram [512];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err), .busy(busy),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] pat(int i, logic [DW-1:0] s);
    return DW'(i * 'h1111) + s;
  endfunction

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_load) for (int i = 0; i < 512; i++) ram[i] <= pat(i, ram_seed);
    else if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic rst;
    logic r0; logic [1:0] c0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1; logic [1:0] c1; logic [AW-1:0] a1; logic [DW-1:0] d1;
  } in_t;

  typedef struct {
    logic [1:0] gnt, rv;
    logic [DW-1:0] rd0, rd1;
    logic [1:0] mcmd;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic err, busy;
  } out_t;

  typedef struct { in_t vi; out_t vo; } vec_t;

  function automatic in_t I(logic rst, logic r0, logic [1:0] c0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                            logic r1, logic [1:0] c1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    in_t x;
    x.rst = rst; x.r0 = r0; x.c0 = c0; x.a0 = a0; x.d0 = d0;
    x.r1 = r1; x.c1 = c1; x.a1 = a1; x.d1 = d1;
    return x;
  endfunction

  function automatic out_t O(logic [1:0] gnt, logic [1:0] rv, logic [DW-1:0] rd0, logic [DW-1:0] rd1,
                             logic [1:0] mcmd, logic [AW-1:0] maddr, logic [DW-1:0] mwd,
                             logic e, logic b);
    out_t y;
    y.gnt = gnt; y.rv = rv; y.rd0 = rd0; y.rd1 = rd1; y.mcmd = mcmd;
    y.maddr = maddr; y.mwd = mwd; y.err = e; y.busy = b;
    return y;
  endfunction

  function automatic vec_t V(in_t a, out_t b);
    vec_t v;
    v.vi = a; v.vo = b;
    return v;
  endfunction

  task automatic drive(in_t x);
    reset = x.rst;
    req0 = x.r0; cmd0 = x.c0; addr0 = x.a0; wdata0 = x.d0;
    req1 = x.r1; cmd1 = x.c1; addr1 = x.a1; wdata1 = x.d1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_outs(out_t e, string tag);
    chk({tag, ".gnt"},    {30'b0, gnt1, gnt0},       32'(e.gnt));
    chk({tag, ".rvalid"}, {30'b0, rvalid1, rvalid0}, 32'(e.rv));
    chk({tag, ".rdata0"}, 32'(rdata0),    32'(e.rd0));
    chk({tag, ".rdata1"}, 32'(rdata1),    32'(e.rd1));
    chk({tag, ".mem_cmd"},   32'(mem_cmd),   32'(e.mcmd));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e.maddr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(e.mwd));
    chk({tag, ".err"},  32'(err),  32'(e.err));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  in_t  idl, both;
  out_t e;

  // reference-model state for the random phase
  logic [DW-1:0] shadow [512];
  int            free_at, lt;
  logic          last, lid, w;
  logic [1:0]    lcmd;
  logic [AW-1:0] laddr, m_addr;
  logic [DW-1:0] lwd, lrd, m_wd;
  logic [DW-1:0] m_rd [2];
  logic          m_err;
  logic [1:0]    prev_gnt;
  logic          act [2];
  logic [1:0]    rc [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rw [2];

  initial begin
    idl = I(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // per-cycle vectors: inputs applied this cycle, outputs expected this cycle
    tbl.push_back(V(I(0,0,0,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(V(I(0,0,0,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(V(I(1,1,MWRITE,5,16'hBEEF,0,0,0,0), O(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(V(I(1,1,MWRITE,5,16'hBEEF,0,0,0,0), O(2'b01,0,0,0,MWRITE,5,16'hBEEF,0,1)));
    tbl.push_back(V(I(1,0,0,0,0,1,MREAD,5,0),         O(0,0,0,0,MNONE,5,16'hBEEF,0,0)));
    tbl.push_back(V(I(1,0,0,0,0,1,MREAD,5,0),         O(2'b10,0,0,0,MREAD,5,0,0,1)));
    tbl.push_back(V(idl,                              O(0,0,0,0,MNONE,5,0,0,1)));
    tbl.push_back(V(I(1,1,MREAD,1,0,0,0,0,0),         O(0,2'b10,0,16'hBEEF,MNONE,5,0,0,0)));
    tbl.push_back(V(I(1,1,MREAD,1,0,0,0,0,0),         O(2'b01,0,0,16'hBEEF,MREAD,1,0,0,1)));
    tbl.push_back(V(I(1,1,MREAD,2,0,0,0,0,0),         O(0,0,0,16'hBEEF,MNONE,1,0,0,1)));
    tbl.push_back(V(I(1,1,MREAD,2,0,0,0,0,0),         O(0,2'b01,16'h1111,16'hBEEF,MNONE,1,0,0,0)));
    tbl.push_back(V(I(1,1,MREAD,2,0,0,0,0,0),         O(2'b01,0,16'h1111,16'hBEEF,MREAD,2,0,0,1)));
    tbl.push_back(V(idl,                              O(0,0,16'h1111,16'hBEEF,MNONE,2,0,0,1)));
    tbl.push_back(V(I(1,1,2'b11,7,0,0,0,0,0),         O(0,2'b01,16'h2222,16'hBEEF,MNONE,2,0,0,0)));
    tbl.push_back(V(I(1,1,2'b11,7,0,0,0,0,0),         O(2'b01,0,16'h2222,16'hBEEF,MNONE,7,0,1,1)));
    tbl.push_back(V(I(1,0,0,0,0,1,MWRITE,3,16'h1234), O(0,0,16'h2222,16'hBEEF,MNONE,7,0,1,0)));
    tbl.push_back(V(I(1,0,0,0,0,1,MWRITE,3,16'h1234), O(2'b10,0,16'h2222,16'hBEEF,MWRITE,3,16'h1234,1,1)));
    tbl.push_back(V(idl,                              O(0,0,16'h2222,16'hBEEF,MNONE,3,16'h1234,1,0)));

    ram_seed = '0;
    ram_load = 1'b1;
    drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    ram_load = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].vi);
      @(negedge clk);
      check_outs(tbl[k].vo, $sformatf("vec%0d", k));
      step();
    end

    // Both requesters held: grants alternate 0,1,0,1; err stays sticky.
    both = I(1, 1, MWRITE, 10, 16'hAAAA, 1, MWRITE, 20, 16'h5555);
    for (int k = 0; k < 9; k++) begin
      drive(k < 8 ? both : idl);
      @(negedge clk);
      chk($sformatf("alt%0d.gnt", k), {30'b0, gnt1, gnt0},
          (k % 2 == 1) ? ((k % 4 == 1) ? 32'd1 : 32'd2) : 32'd0);
      chk($sformatf("alt%0d.err", k), 32'(err), 32'd1);
      step();
    end

    // Reset lands in the RDATA cycle of a requester-1 read.
    drive(I(1, 0, 0, 0, 0, 1, MREAD, 5, 0));
    step();
    @(negedge clk);
    chk("rst.gnt1", {30'b0, gnt1, gnt0}, 32'd2);
    step();
    drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst.busy_rdata", 32'(busy), 32'd1);
    step();
    drive(I(1, 1, MWRITE, 6, 16'h0101, 1, MWRITE, 7, 16'h0202));
    @(negedge clk);
    check_outs(O(0, 0, 0, 0, MNONE, 0, 0, 0, 0), "rst.values");
    step();
    @(negedge clk);
    check_outs(O(2'b01, 0, 0, 0, MWRITE, 6, 16'h0101, 0, 1), "rst.after");
    step();
    drive(idl);
    step();

    // Random phase: reload RAM, reset, then run against the timeline model.
    ram_seed = 16'h3C5A;
    ram_load = 1'b1;
    drive(I(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    ram_load = 1'b0;
    step();
    for (int i = 0; i < 512; i++) shadow[i] = pat(i, 16'h3C5A);
    free_at = 0; lt = -100; last = 1'b1; lid = 1'b0; lcmd = MNONE;
    laddr = '0; lwd = '0; lrd = '0; m_addr = '0; m_wd = '0;
    m_rd[0] = '0; m_rd[1] = '0; m_err = 1'b0; prev_gnt = '0;
    act[0] = 1'b0; act[1] = 1'b0;

    for (int p = 0; p < NR; p++) begin
      e.gnt = '0; e.rv = '0; e.mcmd = MNONE;
      if (lt == p - 1) begin
        e.gnt = lid ? 2'b10 : 2'b01;
        if (lcmd == MREAD || lcmd == MWRITE) e.mcmd = lcmd;
        else m_err = 1'b1;
        m_addr = laddr;
        m_wd = lwd;
      end
      if (lt == p - 3 && lcmd == MREAD) begin
        e.rv = lid ? 2'b10 : 2'b01;
        m_rd[lid] = lrd;
      end
      e.rd0 = m_rd[0]; e.rd1 = m_rd[1];
      e.maddr = m_addr; e.mwd = m_wd; e.err = m_err;
      e.busy = (p > lt) && (p < free_at);

      for (int i = 0; i < 2; i++) begin
        if (act[i] && prev_gnt[i]) act[i] = 1'b0;
        if (!act[i] && $urandom_range(0, 99) < 45) begin
          int r;
          r = $urandom_range(0, 99);
          act[i] = 1'b1;
          rc[i] = (r < 4) ? ((r % 2 == 1) ? 2'b11 : 2'b00) : ((r % 2 == 1) ? MREAD : MWRITE);
          ra[i] = AW'($urandom_range(0, 15));
          rw[i] = DW'($urandom);
        end
      end
      drive(I(1, act[0], rc[0], ra[0], rw[0], act[1], rc[1], ra[1], rw[1]));
      prev_gnt = e.gnt;
      @(negedge clk);
      check_outs(e, $sformatf("rnd%0d", p));

      if (p >= free_at && (act[0] || act[1])) begin
        w = (act[0] && act[1]) ? ~last : act[1];
        last = w; lid = w; lt = p;
        lcmd = rc[w]; laddr = ra[w]; lwd = rw[w];
        if (lcmd == MWRITE) shadow[laddr] = lwd;
        if (lcmd == MREAD) lrd = shadow[laddr];
        free_at = p + ((lcmd == MREAD) ? 3 : 2);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port RAM (MNONE/MREAD/MWRITE command interface) between the CPU and a second master (program loader / debug port). It sits between the requesters and the RAM, serialises accesses with round-robin fairness, drives the RAM command, address and write-data, and returns registered read data with a valid pulse. The RAM is synchronous with a one-cycle read latency.

## Interface
- AW, 9, address width (RAM is 512 words)
- DW, 16, data width
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- req0 / req1  in  1  access request from requester 0 (CPU) / 1 (loader)
- cmd0 / cmd1  in  2  MREAD=2'b01, MWRITE=2'b10; other codes are illegal
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: the request was issued to RAM this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds new read data
- rdata0 / rdata1  out  DW  registered read data; holds until that requester's next read completes
- err  out  1  sticky: an illegal cmd was granted; cleared only by reset
- busy  out  1  high whenever state is not IDLE
- mem_cmd  out  2  to RAM; MNONE=2'b00 except in the ACCESS cycle
- mem_addr  out  AW  to RAM
- mem_wdata  out  DW  to RAM
- mem_rdata  in  DW  from RAM, valid the cycle after an MREAD

## Operation
- States: IDLE, ACCESS, RDATA.
- IDLE: sample req0/req1. None: stay. One: that requester wins. Both: winner is the one not granted last (last_gnt flag). Latch winner's cmd/addr/wdata and winner id into registers; go to ACCESS.
- ACCESS: drive mem_cmd/mem_addr/mem_wdata from latched registers; assert gnt of winner; update last_gnt. MWRITE -> IDLE. MREAD -> RDATA. Illegal cmd: mem_cmd stays MNONE, err set, gnt still pulses, -> IDLE.
- RDATA: capture mem_rdata into rdata of winner at clock edge; -> IDLE; rvalid of winner is high in the following (IDLE) cycle.
- IDLE re-arbitrates in the same cycle rvalid is high.
- Requester rules: hold req/cmd/addr/wdata stable until gnt seen; drop req the cycle after gnt unless issuing a new access. A req still high in IDLE is a new request.
- Only the winner's gnt/rvalid/rdata change; the other requester's rdata is untouched.
- Reset (any state, including mid-read): state IDLE, last_gnt selects requester 0 first, mem_cmd=MNONE, mem_addr=0, mem_wdata=0, gnt*=0, rvalid*=0, rdata*=0, err=0, busy=0. An in-flight read is dropped with no rvalid.

## Timing
- Request seen in IDLE at cycle N -> gnt and RAM command in N+1.
- Write: RAM written at end of N+1; arbiter in IDLE at N+2. Peak throughput one write per 2 cycles.
- Read: mem_rdata valid in N+2, captured at end of N+2, rvalidN and rdataN at N+3. Peak one read per 3 cycles.
- All outputs registered; no combinational path from req/cmd/addr or mem_rdata to any output.
- Starvation bound: a held request is granted within one other access (worst case 3 cycles of wait plus its own latency).

## Structure
- Package mem_arb_pkg: MNONE/MREAD/MWRITE constants (shared with the CPU and StateController), arbiter state enum, requester-id type.
- Sub-module rr_pick2: combinational 2-way round-robin picker (req0, req1, last_gnt -> valid, winner); the arbiter holds last_gnt and all state.

## Test plan
- After reset, req0 MWRITE addr 9'h005 wdata 16'hBEEF alone -> gnt0 at N+1 with mem_cmd=2'b10, mem_addr=5, mem_wdata=BEEF; mem_cmd=2'b00 at N+2.
- req1 MREAD addr 9'h005 (RAM model returns BEEF) -> gnt1 at N+1, rvalid1 with rdata1=16'hBEEF at N+3; rdata0 unchanged at 0.
- req0 and req1 both held high continuously -> grants alternate 0,1,0,1 starting with requester 0; no requester waits two consecutive accesses.
- Back-to-back reads by req0 to addr 1 then 2 (data 16'h1111, 16'h2222) -> rvalid0 pulses 3 cycles apart with correct data each time; second request arbitrated in same cycle as first rvalid0.
- req0 cmd 2'b11 -> gnt0 pulses, mem_cmd stays 2'b00, err=1 and stays 1 across later legal accesses until reset.
- Assert reset=0 during RDATA of a req1 read -> next cycle all outputs at reset values, no rvalid1; after release, simultaneous requests grant requester 0 first.
